// File: rtl/store_chk_pkg.sv
// Shared types for the store trace checker.
//   state_e       : verdict FSM states
//   BYTES_*       : store width encodings on the processor store bus
//   trace_entry_t : one logged store {addr, data, bytes, pc}, 98 bits
//   bytes_mask()  : data bits that take part in the verdict comparison
package store_chk_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StPass,
    StFail,
    StTmo
  } state_e;

  localparam logic [1:0] BYTES_WORD = 2'b00;
  localparam logic [1:0] BYTES_BYTE = 2'b01;
  localparam logic [1:0] BYTES_HALF = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  bytes;
    logic [31:0] pc;
  } trace_entry_t;

  localparam int unsigned TraceEntryW = $bits(trace_entry_t);

  // The reserved encoding 2'b11 compares the full word.
  function automatic logic [31:0] bytes_mask(input logic [1:0] width);
    logic [31:0] mask;
    case (width)
      BYTES_BYTE: mask = 32'h0000_00ff;
      BYTES_HALF: mask = 32'h0000_ffff;
      default:    mask = 32'hffff_ffff;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with asynchronous active-low reset.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i        : write request; accepted when not full, or when full with an accepted pop
//   pop_i         : read request; ignored while empty
//   wdata_i       : data to write
//   rdata_o       : current head entry (combinational)
//   full_o/empty_o: occupancy flags
//   count_o       : number of entries held
module trace_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 98,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the head slot this cycle, so a push to a full FIFO can reuse it.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/store_trace_checker.sv
// Store trace checker: logs every processor store into a trace FIFO and
// renders a pass/fail/timeout verdict against one expected store.
//   clk, reset          : clock, async active-low reset
//   memwrite, aluout,   : store bus from the processor (strobe, address,
//   writedata, bytes, pc  data, width, PC of the storing instruction)
//   rd_en               : pop request for the trace FIFO
//   rd_valid, rd_*      : popped entry, valid one cycle after an accepted pop
//   count               : entries held
//   overflow            : sticky, a store was dropped on a full FIFO
//   done/pass/fail/     : verdict flags
//   timed_out
module store_trace_checker
  import store_chk_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] EXP_ADDR = 32'd76,
  parameter logic [31:0] EXP_DATA = 32'd7,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [31:0]              aluout,
  input  logic [31:0]              writedata,
  input  logic [1:0]               bytes,
  input  logic [31:0]              pc,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [31:0]              rd_addr,
  output logic [31:0]              rd_data,
  output logic [1:0]               rd_bytes,
  output logic [31:0]              rd_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timed_out
);

  localparam int unsigned CycW = $clog2(TIMEOUT) + 1;

  state_e          state_q, state_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic            overflow_q, overflow_d;
  logic            pass_q, fail_q, tmo_q;
  logic            rd_valid_q;
  trace_entry_t    rd_entry_q;

  trace_entry_t    push_entry, head_entry;
  logic            push, pop_ok, fifo_full, fifo_empty;
  logic            hit_addr, data_match;

  assign push       = memwrite && (state_q != StIdle);
  assign pop_ok     = rd_en && !fifo_empty;
  assign push_entry = '{addr: aluout, data: writedata, bytes: bytes, pc: pc};

  trace_fifo #(
    .Depth (DEPTH),
    .Width (TraceEntryW)
  ) u_trace_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .pop_i   (rd_en),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign hit_addr   = memwrite && (aluout == EXP_ADDR);
  assign data_match = ((writedata ^ EXP_DATA) & bytes_mask(bytes)) == 32'h0;

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    overflow_d = overflow_q | (push && fifo_full && !pop_ok);
    case (state_q)
      StIdle: state_d = StRun;
      StRun: begin
        // A qualifying store on the final cycle beats the timeout.
        if (hit_addr) begin
          state_d = data_match ? StPass : StFail;
        end else if (cyc_q == CycW'(TIMEOUT - 1)) begin
          state_d = StTmo;
        end
        if (cyc_q != '1) cyc_d = cyc_q + CycW'(1);
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      overflow_q <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      tmo_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_entry_q <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      overflow_q <= overflow_d;
      pass_q     <= (state_d == StPass);
      fail_q     <= (state_d == StFail);
      tmo_q      <= (state_d == StTmo);
      rd_valid_q <= pop_ok;
      if (pop_ok) rd_entry_q <= head_entry;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_addr   = rd_entry_q.addr;
  assign rd_data   = rd_entry_q.data;
  assign rd_bytes  = rd_entry_q.bytes;
  assign rd_pc     = rd_entry_q.pc;
  assign overflow  = overflow_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timed_out = tmo_q;
  assign done      = pass_q | fail_q | tmo_q;

endmodule

// File: tb/tb_store_trace_checker.sv
module tb_store_trace_checker;

  localparam int unsigned DEPTH    = 8;
  localparam logic [31:0] EXP_ADDR = 32'd76;
  localparam logic [31:0] EXP_DATA = 32'd7;
  localparam int unsigned TIMEOUT  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] aluout, writedata, pc;
  logic [1:0]  bytes;
  logic        rd_en;
  logic        rd_valid;
  logic [31:0] rd_addr, rd_data, rd_pc;
  logic [1:0]  rd_bytes;
  logic [$clog2(DEPTH):0] count;
  logic        overflow, done, pass, fail, timed_out;

  store_trace_checker #(
    .DEPTH    (DEPTH),
    .EXP_ADDR (EXP_ADDR),
    .EXP_DATA (EXP_DATA),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .aluout    (aluout),
    .writedata (writedata),
    .bytes     (bytes),
    .pc        (pc),
    .rd_en     (rd_en),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_bytes  (rd_bytes),
    .rd_pc     (rd_pc),
    .count     (count),
    .overflow  (overflow),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .timed_out (timed_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  bytes;
    logic [31:0] pc;
  } ent_t;

  // Reference model: verdict as a small integer, FIFO as a queue.
  localparam int MIdle = 0, MRun = 1, MPass = 2, MFail = 3, MTmo = 4;
  ent_t        m_fifo[$];
  ent_t        sb[$];
  int          m_state;
  int          m_cyc;
  bit          m_ovf;
  logic [31:0] pc_v;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_match(input logic [31:0] d, input logic [1:0] b);
    case (b)
      2'b01:   return (d % 256) == (EXP_DATA % 256);
      2'b10:   return (d % 65536) == (EXP_DATA % 65536);
      default: return d == EXP_DATA;
    endcase
  endfunction

  // Scoreboard monitor: every rd_valid must match the next expected pop.
  always @(negedge clk) begin
    if (rd_valid) begin
      if (sb.size() == 0) begin
        chk("rd_valid_spurious", 32'(rd_valid), 32'd0);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("rd_addr", rd_addr, e.addr);
        chk("rd_data", rd_data, e.data);
        chk("rd_bytes", 32'(rd_bytes), 32'(e.bytes));
        chk("rd_pc", rd_pc, e.pc);
      end
    end
  end

  task automatic check_state();
    chk("count", 32'(count), 32'(m_fifo.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("done", 32'(done), 32'(m_state >= MPass));
    chk("pass", 32'(pass), 32'(m_state == MPass));
    chk("fail", 32'(fail), 32'(m_state == MFail));
    chk("timed_out", 32'(timed_out), 32'(m_state == MTmo));
    chk("rd_valid", 32'(rd_valid), 32'(sb.size() != 0));
  endtask

  task automatic cycle(input bit mw, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] b, input bit re);
    bit popped, full;
    memwrite  = mw;
    aluout    = a;
    writedata = d;
    bytes     = b;
    pc        = pc_v;
    rd_en     = re;
    full   = (m_fifo.size() == DEPTH);
    popped = re && (m_fifo.size() > 0);
    if (popped) sb.push_back(m_fifo.pop_front());
    if (mw && m_state != MIdle) begin
      if (!full || popped) m_fifo.push_back('{addr: a, data: d, bytes: b, pc: pc_v});
      else m_ovf = 1'b1;
    end
    if (m_state == MIdle) begin
      m_state = MRun;
    end else if (m_state == MRun) begin
      if (mw && a == EXP_ADDR) m_state = model_match(d, b) ? MPass : MFail;
      else if (m_cyc == TIMEOUT - 1) m_state = MTmo;
      m_cyc++;
    end
    pc_v += 4;
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle(input bit re);
    cycle(1'b0, 32'd0, 32'd0, 2'b00, re);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_addr"}, rd_addr, 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_rd_bytes"}, 32'(rd_bytes), 32'd0);
    chk({tag, "_rd_pc"}, rd_pc, 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_timed_out"}, 32'(timed_out), 32'd0);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases after one edge.
  task automatic do_reset(input string tag);
    memwrite = 1'b0;
    rd_en    = 1'b0;
    reset    = 1'b0;
    m_fifo.delete();
    sb.delete();
    m_state = MIdle;
    m_cyc   = 0;
    m_ovf   = 1'b0;
    #2;
    check_zero(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    pc_v      = 32'h0040_0000;
    aluout    = '0;
    writedata = '0;
    bytes     = '0;
    pc        = '0;
    #1;

    // Matching word store, then pop it back.
    do_reset("rst0");
    idle(1'b0);
    cycle(1'b1, 32'd76, 32'd7, 2'b00, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Other-address store is only logged; mismatching store fails.
    do_reset("rst1");
    idle(1'b0);
    cycle(1'b1, 32'd80, 32'd3, 2'b00, 1'b0);
    cycle(1'b1, 32'd76, 32'd9, 2'b00, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Byte store compares only the low byte; halfword mismatch fails.
    do_reset("rst2");
    idle(1'b0);
    cycle(1'b1, 32'd76, 32'hffff_ff07, 2'b01, 1'b0);
    do_reset("rst3");
    idle(1'b0);
    cycle(1'b1, 32'd76, 32'h0001_0107, 2'b10, 1'b0);

    // Timeout, then a late matching store is logged but cannot change the verdict.
    do_reset("rst4");
    for (int i = 0; i < TIMEOUT + 20 && m_state != MTmo; i++) idle(1'b0);
    chk("tmo_reached", 32'(timed_out), 32'd1);
    idle(1'b0);
    cycle(1'b1, 32'd76, 32'd7, 2'b00, 1'b0);
    idle(1'b0);

    // Overflow, then a push with a simultaneous pop on a full FIFO.
    do_reset("rst5");
    idle(1'b0);
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 32'd100 + 32'(4 * i), 32'(i), 2'b00, 1'b0);
    cycle(1'b1, 32'd200, 32'd55, 2'b00, 1'b1);
    for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    idle(1'b0);

    // Mid-run reset clears everything; the next store is judged afresh.
    do_reset("rst6");
    idle(1'b0);
    cycle(1'b1, 32'd80, 32'd1, 2'b00, 1'b0);
    cycle(1'b1, 32'd84, 32'd2, 2'b00, 1'b0);
    cycle(1'b1, 32'd76, 32'd7, 2'b00, 1'b0);
    do_reset("midrst");
    idle(1'b0);
    cycle(1'b1, 32'd76, 32'd7, 2'b00, 1'b0);

    // Randomized traffic with occasional resets.
    do_reset("rst7");
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, d;
      int sel;
      if ($urandom_range(0, 99) == 0) begin
        do_reset("rndrst");
      end
      sel = int'($urandom_range(0, 3));
      a = (sel == 0) ? EXP_ADDR : (sel == 1) ? 32'd80 : ($urandom() & 32'hffff_fffc);
      d = ($urandom_range(0, 1) == 0) ? (($urandom() & 32'hffff_ff00) | EXP_DATA) : $urandom();
      cycle(($urandom_range(0, 19) == 0), a, d, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 3) == 0) cycle(1'b1, 32'd96, $urandom(), 2'b00, 1'b0);
    end
    idle(1'b0);
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
